// File: rtl/score_mem_pkg.sv
// Shared widths, player-id constants and scan state encoding for the
// score RAM responder.
package score_mem_pkg;

  localparam int SCORE_ADDR_W = 5;
  localparam int SCORE_DATA_W = 7;
  localparam int SCORE_ID_W   = 3;

  localparam logic [SCORE_ID_W-1:0] NO_PLAYER_ID = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/score_read_pipe.sv
// Launch/data delay line for the tracker read port: data captured on the
// launch edge reaches o_data READ_LAT-1 edges later and holds otherwise.
module score_read_pipe #(
  parameter int DATA_W   = 7,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_launch,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_out;

  generate
    if (READ_LAT <= 1) begin : g_direct
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_out <= '0;
        end else if (i_launch) begin
          r_out <= i_data;
        end
      end
    end else begin : g_delay
      localparam int D = READ_LAT - 1;

      logic [D-1:0]      r_vld;
      logic [DATA_W-1:0] r_dat [D];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld <= '0;
          for (int i = 0; i < D; i++) r_dat[i] <= '0;
          r_out <= '0;
        end else begin
          r_vld[0] <= i_launch;
          if (i_launch) r_dat[0] <= i_data;
          for (int i = 1; i < D; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_dat[i] <= r_dat[i-1];
          end
          if (r_vld[D-1]) r_out <= r_dat[D-1];
        end
      end
    end
  endgenerate

  assign o_data = r_out;

endmodule

// File: rtl/score_ram_responder.sv
// Score RAM responder: single-ported score array serving the tracker, plus a
// leaderboard scan that borrows the read port only in host-idle cycles.
//
//   state  | meaning
//   S_IDLE | waiting for scan_req
//   S_SCAN | sweeping entries 0..SCAN_ENTRIES-1, stalled while host busy
//   S_DONE | result published, scan_done high for this cycle
module score_ram_responder
  import score_mem_pkg::*;
#(
  parameter int ADDR_W       = SCORE_ADDR_W,
  parameter int DATA_W       = SCORE_DATA_W,
  parameter int READ_LAT     = 2,
  parameter int SCAN_ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RAM_W,
  input  logic                  RAM_R,
  input  logic [ADDR_W-1:0]     RAM_addr,
  input  logic [DATA_W-1:0]     RAM_out,
  output logic [DATA_W-1:0]     RAM_data,
  input  logic                  scan_req,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic [SCORE_ID_W-1:0] best_id,
  output logic [DATA_W-1:0]     best_score
);

  localparam logic [SCORE_ID_W-1:0] LAST_IDX = SCORE_ID_W'(SCAN_ENTRIES - 1);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  scan_state_t           r_state, w_state_nxt;
  logic [SCORE_ID_W-1:0] r_idx, w_idx_nxt;
  logic [DATA_W-1:0]     r_acc_score, w_acc_score_nxt;
  logic [SCORE_ID_W-1:0] r_acc_id, w_acc_id_nxt;
  logic [DATA_W-1:0]     r_best_score, w_best_score_nxt;
  logic [SCORE_ID_W-1:0] r_best_id, w_best_id_nxt;

  logic              w_host_busy;
  logic              w_launch;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_better;

  assign w_host_busy = RAM_R | RAM_W;
  assign w_launch    = RAM_R & ~RAM_W;
  assign w_rd_addr   = w_host_busy ? RAM_addr : ADDR_W'(r_idx);
  assign w_rd_data   = r_mem[w_rd_addr];
  assign w_better    = w_rd_data > r_acc_score;

  // Contents are left unreset; the tracker's init sweep clears them.
  always_ff @(posedge clk) begin
    if (RAM_W) r_mem[RAM_addr] <= RAM_out;
  end

  score_read_pipe #(
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_launch(w_launch),
    .i_data  (w_rd_data),
    .o_data  (RAM_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_acc_score  <= '0;
      r_acc_id     <= NO_PLAYER_ID;
      r_best_score <= '0;
      r_best_id    <= NO_PLAYER_ID;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_acc_score  <= w_acc_score_nxt;
      r_acc_id     <= w_acc_id_nxt;
      r_best_score <= w_best_score_nxt;
      r_best_id    <= w_best_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_acc_score_nxt  = r_acc_score;
    w_acc_id_nxt     = r_acc_id;
    w_best_score_nxt = r_best_score;
    w_best_id_nxt    = r_best_id;
    unique case (r_state)
      S_IDLE: begin
        if (scan_req) begin
          w_state_nxt     = S_SCAN;
          w_idx_nxt       = '0;
          w_acc_score_nxt = '0;
          w_acc_id_nxt    = NO_PLAYER_ID;
        end
      end
      S_SCAN: begin
        if (!w_host_busy) begin
          if (w_better) begin
            w_acc_score_nxt = w_rd_data;
            w_acc_id_nxt    = r_idx;
          end
          w_idx_nxt = r_idx + SCORE_ID_W'(1);
          // Publish on entry to S_DONE so the result is valid alongside scan_done.
          if (r_idx == LAST_IDX) begin
            w_state_nxt      = S_DONE;
            w_best_score_nxt = w_acc_score_nxt;
            w_best_id_nxt    = w_acc_id_nxt;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign scan_busy  = (r_state == S_SCAN);
  assign scan_done  = (r_state == S_DONE);
  assign best_id    = r_best_id;
  assign best_score = r_best_score;

endmodule

// File: tb/tb_score_ram_responder.sv
// Directed bench for score_ram_responder with a queue/array reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_score_ram_responder;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 7;
  localparam int READ_LAT = 2;
  localparam int SCAN_ENTRIES = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              RAM_W = 1'b0;
  logic              RAM_R = 1'b0;
  logic [ADDR_W-1:0] RAM_addr = '0;
  logic [DATA_W-1:0] RAM_out = '0;
  logic [DATA_W-1:0] RAM_data;
  logic              scan_req = 1'b0;
  logic              scan_busy;
  logic              scan_done;
  logic [2:0]        best_id;
  logic [DATA_W-1:0] best_score;

  score_ram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .SCAN_ENTRIES(SCAN_ENTRIES)
  ) dut (
    .clk(clk), .rst(rst), .RAM_W(RAM_W), .RAM_R(RAM_R), .RAM_addr(RAM_addr),
    .RAM_out(RAM_out), .RAM_data(RAM_data), .scan_req(scan_req),
    .scan_busy(scan_busy), .scan_done(scan_done), .best_id(best_id),
    .best_score(best_score)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int               due;
    logic [DATA_W-1:0] d;
  } rd_t;

  logic [DATA_W-1:0] m_mem [32];
  rd_t               m_q[$];
  int                m_edge = 0;
  logic [DATA_W-1:0] exp_data = '0;
  bit                m_busy = 0;
  bit                m_done = 0;
  int                m_left = 0;
  int                exp_id = 7;
  int                exp_score = 0;

  function automatic void best_of(output int id, output int sc);
    sc = 0;
    id = 7;
    for (int i = 0; i < SCAN_ENTRIES; i++)
      if (int'(m_mem[i]) > sc) begin
        sc = int'(m_mem[i]);
        id = i;
      end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      exp_data = '0;
      m_busy = 0;
      m_done = 0;
      m_left = 0;
      exp_id = 7;
      exp_score = 0;
    end else begin
      m_edge++;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        if (!(RAM_R || RAM_W)) m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          best_of(exp_id, exp_score);
        end
      end else if (scan_req) begin
        m_busy = 1;
        m_left = SCAN_ENTRIES;
      end
      if (RAM_R && !RAM_W) m_q.push_back('{due: m_edge + READ_LAT - 1, d: m_mem[RAM_addr]});
      if (RAM_W) m_mem[RAM_addr] = RAM_out;
      while (m_q.size() > 0 && m_q[0].due <= m_edge) begin
        exp_data = m_q[0].d;
        m_q.delete(0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ram_data", 32'(RAM_data), 32'(exp_data));
      check("scan_busy", 32'(scan_busy), 32'(m_busy));
      check("scan_done", 32'(scan_done), 32'(m_done));
      check("best_id", 32'(best_id), exp_id);
      check("best_score", 32'(best_score), exp_score);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    RAM_W = 1'b1;
    RAM_addr = ADDR_W'(a);
    RAM_out = DATA_W'(d);
    step();
    RAM_W = 1'b0;
  endtask

  task automatic rd(input int a);
    RAM_R = 1'b1;
    RAM_addr = ADDR_W'(a);
    step();
    RAM_R = 1'b0;
  endtask

  task automatic load_table(input int v0, input int v1, input int v2, input int v3,
                            input int v4, input int v5, input int v6, input int v7);
    int vals[8];
    vals = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 8; i++) wr(i, vals[i]);
  endtask

  // Counts edges from the scan_req sampling edge (1) to scan_done seen high.
  task automatic run_scan(input int stall_after, input int stall_len, output int n);
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    n = 1;
    while (scan_done !== 1'b1 && n < 60) begin
      if (stall_len > 0 && n == stall_after) begin
        RAM_R = 1'b1;
        RAM_addr = ADDR_W'(4);
        repeat (stall_len) begin
          step();
          n++;
        end
        RAM_R = 1'b0;
        check("stall_ram_data", 32'(RAM_data), 32'd20);
      end else begin
        step();
        n++;
      end
    end
  endtask

  initial begin
    int n;
    int done_cnt;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    check("rst_ram_data", 32'(RAM_data), 32'd0);
    check("rst_busy", 32'(scan_busy), 32'd0);
    check("rst_best_id", 32'(best_id), 32'd7);
    check("rst_best_score", 32'(best_score), 32'd0);

    for (int a = 0; a < 32; a++) wr(a, 0);
    rd(5);
    step();
    check("init_read5", 32'(RAM_data), 32'd0);

    wr(3, 45);
    rd(3);
    check("raw_latency_old", 32'(RAM_data), 32'd0);
    step();
    check("raw_read3", 32'(RAM_data), 32'd45);
    repeat (3) step();
    check("hold_read3", 32'(RAM_data), 32'd45);

    RAM_W = 1'b1; RAM_R = 1'b1; RAM_addr = ADDR_W'(2); RAM_out = DATA_W'(99);
    step();
    RAM_W = 1'b0; RAM_R = 1'b0;
    step();
    check("wr_rd_same_cycle_data", 32'(RAM_data), 32'd45);
    rd(2);
    step();
    check("read2_after_wr", 32'(RAM_data), 32'd99);

    load_table(10, 50, 50, 0, 20, 0, 0, 0);
    run_scan(0, 0, n);
    check("scan_cycles", n, 9);
    check("scan_best_id", 32'(best_id), 32'd1);
    check("scan_best_score", 32'(best_score), 32'd50);
    step();
    check("scan_busy_after", 32'(scan_busy), 32'd0);
    check("scan_done_pulse", 32'(scan_done), 32'd0);

    wr(6, 100);
    run_scan(3, 4, n);
    check("stall_cycles", n, 13);
    check("stall_best_id", 32'(best_id), 32'd6);
    check("stall_best_score", 32'(best_score), 32'd100);
    step();

    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(scan_busy), 32'd0);
    check("midrst_done", 32'(scan_done), 32'd0);
    check("midrst_best_id", 32'(best_id), 32'd7);
    check("midrst_best_score", 32'(best_score), 32'd0);
    step();
    rst = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      step();
      if (scan_done === 1'b1) done_cnt++;
    end
    check("no_partial_done", done_cnt, 0);

    run_scan(0, 0, n);
    check("post_rst_cycles", n, 9);
    check("post_rst_best_id", 32'(best_id), 32'd6);
    step();

    load_table(0, 0, 0, 0, 0, 0, 0, 0);
    run_scan(0, 0, n);
    check("zero_best_id", 32'(best_id), 32'd7);
    check("zero_best_score", 32'(best_score), 32'd0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
